// File: rtl/usb2_ep1_fill.sv
// +--------------------------------------------------------------------------+
// | usb2_ep1_fill : byte-stream producer that fills the EP1 IN buffer and    |
// |                 commits full or short packets until the host ACKs them.  |
// | Optional idle flush: define USB2_EP1_FILL_TIMEOUT_EN                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module usb2_ep1_fill #(
  parameter int MAX_PKT        = 512,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic        phy_clk,
  input  logic        reset_n,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  input  logic        src_last,
  output logic        src_ready,
  output logic [8:0]  buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  output logic        pkt_ready,
  output logic [9:0]  pkt_len,
  input  logic        xfer_ack,
  output logic [15:0] pkt_count
);

  localparam logic [9:0]  c_last_idx  = 10'(MAX_PKT - 1);
  localparam logic [15:0] c_idle_term = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_wr_ptr;
  logic [8:0]  r_addr;
  logic [7:0]  r_data;
  logic        r_wren;
  logic        r_pkt_ready;
  logic [9:0]  r_pkt_len;
  logic [15:0] r_pkt_count;
  logic        w_accept;
  logic        w_timeout;

  assign src_ready   = (r_state == ST_FILL);
  assign w_accept    = src_valid & src_ready;
  assign buf_in_addr = r_addr;
  assign buf_in_data = r_data;
  assign buf_in_wren = r_wren;
  assign pkt_ready   = r_pkt_ready;
  assign pkt_len     = r_pkt_len;
  assign pkt_count   = r_pkt_count;

`ifdef USB2_EP1_FILL_TIMEOUT_EN
  logic [15:0] r_idle_cnt;

  // Counts only while a partial packet sits in the buffer with no new bytes.
  assign w_timeout = (r_state == ST_FILL) && !w_accept && (r_wr_ptr != 10'd0) &&
                     (r_idle_cnt == c_idle_term);

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= 16'd0;
    end else if ((r_state != ST_FILL) || w_accept || (r_wr_ptr == 10'd0) || w_timeout) begin
      r_idle_cnt <= 16'd0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end
`else
  // Flush disabled; the terminal count is still referenced so the parameter stays live.
  assign w_timeout = (c_idle_term == 16'hFFFF) & 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RST:    w_state_nxt = ST_FILL;
      ST_FILL: begin
        if (w_accept && (src_last || (r_wr_ptr == c_last_idx))) begin
          w_state_nxt = ST_COMMIT;
        end else if (w_timeout) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (xfer_ack) begin
          w_state_nxt = ST_FILL;
        end
      end
      default:   w_state_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= 10'd0;
      r_addr      <= 9'd0;
      r_data      <= 8'd0;
      r_wren      <= 1'b0;
      r_pkt_ready <= 1'b0;
      r_pkt_len   <= 10'd0;
      r_pkt_count <= 16'd0;
    end else begin
      r_wren <= w_accept;
      if (w_accept) begin
        r_addr   <= r_wr_ptr[8:0];
        r_data   <= src_data;
        r_wr_ptr <= r_wr_ptr + 10'd1;
      end
      if (r_state == ST_COMMIT) begin
        r_pkt_len   <= r_wr_ptr;
        r_pkt_ready <= 1'b1;
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      // Buffer contents stay untouched in hold so the host can re-read them.
      if ((r_state == ST_HOLD) && xfer_ack) begin
        r_pkt_ready <= 1'b0;
        r_wr_ptr    <= 10'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb2_ep1_fill.sv
// +--------------------------------------------------------------------------+
// | tb_usb2_ep1_fill : randomized self-checking bench for usb2_ep1_fill.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_usb2_ep1_fill;

  localparam int MAX_PKT = 512;
  localparam int TIMEOUT = 16;

  logic        phy_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  src_data = 8'd0;
  logic        src_valid = 1'b0;
  logic        src_last = 1'b0;
  logic        src_ready;
  logic [8:0]  buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        pkt_ready;
  logic [9:0]  pkt_len;
  logic        xfer_ack = 1'b0;
  logic [15:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: packet-level view of the producer.
  // m_mode: 0 = just out of reset, 1 = taking bytes, 2 = committing, 3 = waiting for ACK
  int m_mode;
  int m_fill;
  int m_idle;
  bit m_wren;
  int m_addr;
  int m_data;
  bit m_ready;
  int m_len;
  int m_count;

  usb2_ep1_fill #(.MAX_PKT(MAX_PKT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .phy_clk    (phy_clk),
    .reset_n    (reset_n),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_last   (src_last),
    .src_ready  (src_ready),
    .buf_in_addr(buf_in_addr),
    .buf_in_data(buf_in_data),
    .buf_in_wren(buf_in_wren),
    .pkt_ready  (pkt_ready),
    .pkt_len    (pkt_len),
    .xfer_ack   (xfer_ack),
    .pkt_count  (pkt_count)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_idle = 0; m_wren = 0; m_addr = 0; m_data = 0;
    m_ready = 0; m_len = 0; m_count = 0;
  endtask

  task automatic model_edge(input bit v, input int d, input bit l, input bit a);
    bit acc;
    acc = v && (m_mode == 1);
    m_wren = acc;
    if (acc) begin
      m_addr = m_fill % 512;
      m_data = d;
    end
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (acc) begin
          m_fill++;
          m_idle = 0;
          if (l || m_fill == MAX_PKT) m_mode = 2;
        end else begin
`ifdef USB2_EP1_FILL_TIMEOUT_EN
          if (m_fill > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
              m_idle = 0;
              m_mode = 2;
            end
          end
`endif
        end
      end
      2: begin
        m_len = m_fill;
        m_ready = 1;
        m_count = (m_count + 1) % 65536;
        m_mode = 3;
      end
      default: begin
        if (a) begin
          m_ready = 0;
          m_fill = 0;
          m_mode = 1;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check_eq("src_ready", 32'(src_ready), 32'(m_mode == 1));
    check_eq("wren", 32'(buf_in_wren), 32'(m_wren));
    if (m_wren) begin
      check_eq("addr", 32'(buf_in_addr), 32'(m_addr));
      check_eq("data", 32'(buf_in_data), 32'(m_data));
    end
    check_eq("pkt_ready", 32'(pkt_ready), 32'(m_ready));
    check_eq("pkt_len", 32'(pkt_len), 32'(m_len));
    check_eq("pkt_count", 32'(pkt_count), 32'(m_count));
  endtask

  // One clock: inputs applied at the falling edge, outputs checked at the next one.
  task automatic step(input bit v, input int d, input bit l, input bit a);
    src_valid = v;
    src_data  = 8'(d);
    src_last  = l;
    xfer_ack  = a;
    @(posedge phy_clk);
    model_edge(v, d, l, a);
    @(negedge phy_clk);
    compare_all();
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_src_ready", 32'(src_ready), 32'd0);
    check_eq("rst_wren", 32'(buf_in_wren), 32'd0);
    check_eq("rst_addr", 32'(buf_in_addr), 32'd0);
    check_eq("rst_data", 32'(buf_in_data), 32'd0);
    check_eq("rst_pkt_ready", 32'(pkt_ready), 32'd0);
    check_eq("rst_pkt_len", 32'(pkt_len), 32'd0);
    check_eq("rst_pkt_count", 32'(pkt_count), 32'd0);
    model_reset();
    src_valid = 1'b0; src_last = 1'b0; xfer_ack = 1'b0;
    @(negedge phy_clk);
    @(negedge phy_clk);
    reset_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input bit rnd_valid);
    for (int i = 0; i < n; i++) begin
      step(rnd_valid ? bit'($urandom_range(0, 1)) : 1'b0, int'($urandom_range(0, 255)),
           bit'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    model_reset();
    @(negedge phy_clk);
    do_reset();
    step(0, 0, 0, 0);

    // Full-size packet: 512 bytes back to back
    for (int i = 0; i < 512; i++) step(1, i % 256, 0, 0);
    idle_cycles(5, 1);
    step(0, 0, 0, 1);

    // Short packet A1..A5, then refused bytes until the ACK
    for (int i = 0; i < 5; i++) step(1, 8'hA1 + i, (i == 4), 0);
    idle_cycles(4, 1);
    step(0, 0, 0, 1);
    step(1, 8'h5A, 0, 0);
    step(1, 8'h5B, 1, 0);
    step(0, 0, 0, 1);

    // 8-byte packet held for 100 cycles before the ACK
    for (int i = 0; i < 8; i++) step(1, $urandom_range(0, 255), (i == 7), 0);
    idle_cycles(100, 1);
    step(0, 0, 0, 1);
    step(1, 8'h33, 0, 0);

    // ACK during fill is ignored
    step(1, 8'h34, 0, 0);
    step(1, 8'h35, 0, 0);
    step(0, 0, 0, 1);
    step(1, 8'h36, 0, 0);
    step(1, 8'h37, 1, 0);
    step(0, 0, 0, 1);

    // src_last without src_valid is ignored
    step(1, 8'h01, 0, 0);
    step(0, 8'h02, 1, 0);
    step(1, 8'h03, 1, 0);
    step(0, 0, 0, 1);

    // Partial packet left idle (flushed only when the timeout is built in)
    for (int i = 0; i < 3; i++) step(1, 8'hC0 + i, 0, 0);
    idle_cycles(TIMEOUT + 8, 0);
    step(1, 8'hC3, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Randomized traffic with sparse src_last and stray ACKs
    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)),
           bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 7) == 0));
    end
    step(0, 0, 0, 1);

    // Reset in the middle of a packet
    step(0, 0, 0, 0);
    for (int i = 0; i < 200; i++) step(1, i, 0, 0);
    do_reset();
    step(1, 8'hEE, 0, 0);
    step(1, 8'hEF, 0, 0);
    step(1, 8'hF0, 1, 0);
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb2_ep1_fill.md
Name: usb2_ep1_fill

Overview:
- Upstream producer for the USB 2.0 EP1 IN endpoint.
- Accepts a byte stream from application logic using valid/ready. Writes the bytes into the endpoint's 512-byte IN buffer through its buf_in_addr/buf_in_data/buf_in_wren write port.
- Commits a packet, full or short, to the protocol layer with pkt_ready/pkt_len.
- Holds the packet until the host ACKs it, then refills from address 0.

Parameters:
- MAX_PKT, 512: max packet size in bytes. Legal range 1..512. A full-size commit occurs when this count is reached.
- TIMEOUT_CYCLES, 60000: idle cycles before a partial packet is flushed. Used only with USB2_EP1_FILL_TIMEOUT_EN; 60000 cycles is 1 ms at 60 MHz.

Ports:
- phy_clk  in  1  sole clock; all logic on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- src_data  in  8  stream byte.
- src_valid  in  1  src_data valid.
- src_last  in  1  qualifies the current byte as the last byte of a short packet.
- src_ready  out  1  block can accept a byte this cycle.
- buf_in_addr  out  9  endpoint buffer write address.
- buf_in_data  out  8  endpoint buffer write data.
- buf_in_wren  out  1  endpoint buffer write strobe.
- pkt_ready  out  1  committed packet present in the buffer.
- pkt_len  out  10  committed length, 1..MAX_PKT.
- xfer_ack  in  1  1-cycle pulse from the protocol layer: host ACKed the IN data packet.
- pkt_count  out  16  committed packets since reset; wraps at 65535->0.

Behaviour:
- Reset values (asynchronous, while reset_n low):
  - state=ST_RST, wr_ptr=0.
  - buf_in_addr=0, buf_in_data=0, buf_in_wren=0.
  - pkt_ready=0, pkt_len=0, pkt_count=0.
  - src_ready=0.
- src_ready is combinational: (state==ST_FILL). It never depends on src_valid.
- Accept: src_valid & src_ready at edge N.
  - At N+1: buf_in_wren=1, buf_in_addr=wr_ptr, buf_in_data=src_data.
  - wr_ptr increments at N.
  - buf_in_wren is otherwise 0. Write latency is 1 cycle.
- States:
  - ST_RST -> ST_FILL on the first edge after reset release.
  - ST_FILL:
    - Accept with src_last=1 -> ST_COMMIT.
    - Accept where wr_ptr==MAX_PKT-1 -> ST_COMMIT. This applies even if src_last=0.
    - Otherwise stay.
  - ST_COMMIT, one cycle; the last write completes during this cycle:
    - pkt_len <= wr_ptr (the count written).
    - pkt_ready <= 1.
    - pkt_count += 1.
    - -> ST_HOLD.
  - ST_HOLD:
    - src_ready=0.
    - xfer_ack -> pkt_ready <= 0, wr_ptr <= 0 -> ST_FILL.
    - With no ack, stay: retries and NAK/timeout rounds re-read the same data.
- pkt_len/pkt_ready timing: they become valid 2 edges after the final accept and are stable throughout ST_HOLD.
- Widths: wr_ptr is 10 bits, holding 0..512. buf_in_addr is wr_ptr[8:0] at the time of the write.
- Boundary conditions:
  - xfer_ack outside ST_HOLD is ignored; pkt_count and the buffer are unaffected.
  - src_last on the byte that also reaches MAX_PKT gives one commit of length MAX_PKT, not two.
  - src_last with src_valid=0 is ignored.
  - MAX_PKT=1: every accepted byte commits a 1-byte packet.
  - No zero-length packets are ever committed; pkt_len is never 0 after the first commit.
  - Reset mid-packet: the partial packet is discarded, pkt_ready drops immediately, and the next fill starts at address 0.

Optional Feature:
- Macro: USB2_EP1_FILL_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter runs in ST_FILL while wr_ptr>0.
  - It clears on every accept and on leaving ST_FILL.
  - When it reaches TIMEOUT_CYCLES-1, the block enters ST_COMMIT with the current wr_ptr as the length (short packet).
  - An accept in the same cycle as the terminal count wins: the byte is taken and the counter clears.
  - With wr_ptr==0 the counter never runs.
- Undefined: the counter logic is absent; commits occur only on MAX_PKT or src_last.

Test Plan:
- Stream 512 bytes 0x00..0xFF,0x00..0xFF with src_valid held high:
  - buf_in_wren for 512 cycles, addresses 0..511.
  - pkt_ready=1 with pkt_len=512 two edges after the final accept.
  - src_ready=0 from the following cycle; pkt_count=1.
- 5 bytes 0xA1..0xA5 with src_last on 0xA5:
  - pkt_len=5, pkt_ready=1.
  - A further src_valid is not accepted (src_ready=0) until xfer_ack.
  - After xfer_ack: pkt_ready=0; the next byte writes address 0.
- Commit 8-byte packet; hold 100 cycles with no ack; pulse xfer_ack only after that:
  - pkt_ready and pkt_len=8 are stable throughout.
  - The next byte is accepted one cycle after the ack.
- xfer_ack pulsed during ST_FILL after 3 bytes:
  - No effect; wr_ptr continues to 4 on the next accept.
  - pkt_count unchanged.
- Assert reset_n low after 200 of 512 bytes:
  - All outputs at reset values asynchronously.
  - After release, the first accepted byte writes address 0; pkt_count=0.
- With USB2_EP1_FILL_TIMEOUT_EN and TIMEOUT_CYCLES=16, send 3 bytes then idle:
  - pkt_ready with pkt_len=3 after 16 idle cycles.
  - With the macro undefined, no commit occurs.
